// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        LSL = 2'b00,
        LSR = 2'b01,
        ASR = 2'b10,
        ROR = 2'b11
    } shift_op_e;

    // Control fields travelling with each operand; data and remaining amount are sized per instance.
    typedef struct packed {
        shift_op_e op;
        logic      fill;
        logic      carry;
        logic      sat;
    } stage_ctrl_t;

    // Barrel levels owned by stage k; leftover levels go to the earliest stages.
    function automatic int unsigned levels_in_stage(input int unsigned total,
                                                    input int unsigned stages,
                                                    input int unsigned k);
        return total / stages + ((k < total % stages) ? 32'd1 : 32'd0);
    endfunction

    function automatic int unsigned first_level(input int unsigned total,
                                                input int unsigned stages,
                                                input int unsigned k);
        int unsigned base;
        int unsigned extra;
        base  = total / stages;
        extra = total % stages;
        return k * base + ((k < extra) ? k : extra);
    endfunction

endpackage

// File: rtl/pipelined_shifter_stage.sv
// One registered slice of the shifter: applies its barrel levels and owns its valid/advance.
module shifter_stage
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned AMT_WIDTH   = 5,
    parameter int unsigned FIRST_LEVEL = 0,
    parameter int unsigned NUM_LEVELS  = 1,
    parameter bit          LAST        = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [AMT_WIDTH-1:0]  in_amount,
    input  stage_ctrl_t           in_ctrl,
    input  logic                  next_advance,
    output logic                  advance_c,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [AMT_WIDTH-1:0]  out_amount,
    output stage_ctrl_t           out_ctrl
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [AMT_WIDTH-1:0]  amount_q;
    stage_ctrl_t           ctrl_q;
    logic [DATA_WIDTH-1:0] shifted;

    function automatic logic [DATA_WIDTH-1:0] shift_level(input logic [DATA_WIDTH-1:0] d,
                                                          input int unsigned           s,
                                                          input shift_op_e             op,
                                                          input logic                  fill);
        case (op)
            LSL:     return d << s;
            LSR:     return d >> s;
            ASR:     return (d >> s) | (fill ? ~({DATA_WIDTH{1'b1}} >> s) : '0);
            default: return (d >> s) | (d << (DATA_WIDTH - s));
        endcase
    endfunction

    // Saturated shifts are forced to all-fill on the final register only.
    always_comb begin
        shifted = in_data;
        for (int unsigned i = 0; i < NUM_LEVELS; i++) begin
            if (in_amount[AMT_WIDTH'(FIRST_LEVEL + i)]) begin
                shifted = shift_level(shifted, 32'd1 << (FIRST_LEVEL + i), in_ctrl.op, in_ctrl.fill);
            end
        end
        if (LAST && in_ctrl.sat) begin
            shifted = {DATA_WIDTH{in_ctrl.fill}};
        end
    end

    assign advance_c = !valid_q || next_advance;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= 1'b0;
            data_q   <= '0;
            amount_q <= '0;
            ctrl_q   <= '0;
        end else if (advance_c) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q   <= shifted;
                amount_q <= in_amount;
                ctrl_q   <= in_ctrl;
            end
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_amount = amount_q;
    assign out_ctrl   = ctrl_q;

endmodule

// File: rtl/pipelined_shifter.sv
// Elastic pipelined barrel shifter with ARM shift semantics and carry-out.
// Define SHIFTER_RRX_EN to make ROR by zero perform RRX.
module pipelined_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 8,
    parameter int unsigned STAGES      = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHAMT_WIDTH-1:0] in_amount,
    input  logic [1:0]             in_op,
    input  logic                   in_carry,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_carry
);

    localparam int unsigned AMT_WIDTH = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] pre_data;
    stage_ctrl_t           pre_ctrl;
    logic [AMT_WIDTH-1:0]  amt_lo;
    logic [AMT_WIDTH-1:0]  neg_idx;
    logic [AMT_WIDTH-1:0]  dec_idx;
    logic                  amt_zero;
    logic                  amt_over;
    logic                  amt_ge;

    // Pre-decode: carry and saturation are resolved here from the full amount.
    always_comb begin
        amt_lo         = in_amount[AMT_WIDTH-1:0];
        neg_idx        = AMT_WIDTH'(0) - amt_lo;
        dec_idx        = amt_lo - AMT_WIDTH'(1);
        amt_zero       = (in_amount == '0);
        amt_over       = (in_amount > SHAMT_WIDTH'(DATA_WIDTH));
        amt_ge         = (in_amount >= SHAMT_WIDTH'(DATA_WIDTH));
        pre_data       = in_data;
        pre_ctrl.op    = shift_op_e'(in_op);
        pre_ctrl.fill  = 1'b0;
        pre_ctrl.sat   = 1'b0;
        pre_ctrl.carry = in_carry;
        case (pre_ctrl.op)
            LSL: begin
                pre_ctrl.sat = amt_ge;
                if (!amt_zero) pre_ctrl.carry = amt_over ? 1'b0 : in_data[neg_idx];
            end
            LSR: begin
                pre_ctrl.sat = amt_ge;
                if (!amt_zero) pre_ctrl.carry = amt_over ? 1'b0 : in_data[dec_idx];
            end
            ASR: begin
                pre_ctrl.fill = in_data[DATA_WIDTH-1];
                pre_ctrl.sat  = amt_ge;
                if (!amt_zero) pre_ctrl.carry = amt_over ? in_data[DATA_WIDTH-1] : in_data[dec_idx];
            end
            default: begin
                // Index (n-1) mod W also covers the n mod W == 0 case (bit W-1).
                if (!amt_zero) begin
                    pre_ctrl.carry = in_data[dec_idx];
                end else begin
`ifdef SHIFTER_RRX_EN
                    pre_data       = {in_carry, in_data[DATA_WIDTH-1:1]};
                    pre_ctrl.carry = in_data[0];
`else
                    pre_data       = in_data;
`endif
                end
            end
        endcase
    end

    logic [DATA_WIDTH-1:0] st_data  [STAGES+1];
    logic [AMT_WIDTH-1:0]  st_amt   [STAGES+1];
    stage_ctrl_t           st_ctrl  [STAGES+1];
    logic                  st_valid [STAGES+1];

    assign st_data[0]  = pre_data;
    assign st_amt[0]   = amt_lo;
    assign st_ctrl[0]  = pre_ctrl;
    assign st_valid[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic adv_c;
        logic nxt_adv;

        if (k == STAGES - 1) begin : g_tail
            assign nxt_adv = out_ready;
        end else begin : g_link
            assign nxt_adv = g_stage[k+1].adv_c;
        end

        shifter_stage #(
            .DATA_WIDTH (DATA_WIDTH),
            .AMT_WIDTH  (AMT_WIDTH),
            .FIRST_LEVEL(first_level(AMT_WIDTH, STAGES, k)),
            .NUM_LEVELS (levels_in_stage(AMT_WIDTH, STAGES, k)),
            .LAST       (k == STAGES - 1)
        ) u_stage (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (st_valid[k]),
            .in_data     (st_data[k]),
            .in_amount   (st_amt[k]),
            .in_ctrl     (st_ctrl[k]),
            .next_advance(nxt_adv),
            .advance_c   (adv_c),
            .out_valid   (st_valid[k+1]),
            .out_data    (st_data[k+1]),
            .out_amount  (st_amt[k+1]),
            .out_ctrl    (st_ctrl[k+1])
        );
    end

    assign in_ready  = g_stage[0].adv_c;
    assign out_valid = st_valid[STAGES];
    assign out_data  = st_data[STAGES];
    assign out_carry = st_ctrl[STAGES].carry;

    logic unused_tail;
    assign unused_tail = ^{st_amt[STAGES], st_ctrl[STAGES].op, st_ctrl[STAGES].fill, st_ctrl[STAGES].sat};

endmodule
